exe_mul_seq: RTL and testbench
==============================

EXE_MUL_SEQ -- requirements
Module: exe_mul_seq

Interface
REQ-001 Parameter WORD_LEN, default `WORD_LEN (32), operand and result width.
REQ-002 Parameter CNT_LEN, default 5, iteration counter width (log2 WORD_LEN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 EXE_CMD  input  `EXE_CMD_LEN  EXE-stage command; value `EXE_MUL requests a multiply.
REQ-006 val1  input  WORD_LEN  forwarded operand 1 (multiplicand), post forwarding mux.
REQ-007 val2  input  WORD_LEN  forwarded operand 2 (multiplier), post forwarding mux.
REQ-008 alu_res_in  input  WORD_LEN  single-cycle ALU result for non-multiply commands.
REQ-009 exe_stall  output  1  freezes PC, IF/ID, ID/EXE; high while the multiply occupies EXE.
REQ-010 mul_valid  output  1  one-cycle pulse; product is on result_out this cycle.
REQ-011 result_out  output  WORD_LEN  EXE result to the EXE/MEM register.

Function
REQ-012 States IDLE, BUSY, DONE; registered state, 2-bit encoding.
REQ-013 IDLE, EXE_CMD != `EXE_MUL: exe_stall=0, mul_valid=0, result_out=alu_res_in, state stays IDLE.
REQ-014 IDLE, EXE_CMD == `EXE_MUL (accept cycle T0): exe_stall=1 combinationally; latch mcand<=val1, mplr<=val2, prod<=0, cnt<=0.
REQ-015 Accept with val2==0: next state DONE; otherwise next state BUSY.
REQ-016 BUSY, per cycle: if mplr[0]==1, prod<=prod+mcand (mod 2^WORD_LEN); mcand<=mcand<<1; mplr<=mplr>>1 (logical); cnt<=cnt+1; exe_stall=1.
REQ-017 BUSY exit: next state DONE when shifted mplr==0 or cnt==WORD_LEN-1 (max WORD_LEN iterations); else stay BUSY.
REQ-018 DONE: exe_stall=0, mul_valid=1, result_out=prod; unconditional next state IDLE; EXE_CMD ignored (held MUL not re-accepted).
REQ-019 Product is the low WORD_LEN bits of val1*val2; identical for signed and unsigned; no high word, no overflow flag.
REQ-020 Latency: DONE at T0+1+k, k = number of BUSY iterations (bit position of highest set bit of val2, plus 1; 0 for val2==0).
REQ-021 Back-to-back MUL: a MUL entering EXE the cycle after DONE is accepted from IDLE with no bubble beyond that IDLE cycle.
REQ-022 Operands latched only in the accept cycle; val1/val2 changes in BUSY or DONE have no effect.
REQ-023 exe_stall and mul_valid never high in the same cycle.

Reset
REQ-024 rst=1 at a clock edge: state<=IDLE, prod<=0, mcand<=0, mplr<=0, cnt<=0, in any state.
REQ-025 While rst=1 and in the cycle after release: exe_stall=0, mul_valid=0, result_out=alu_res_in.
REQ-026 Reset mid-BUSY abandons the operation; no mul_valid pulse follows.

Structure
REQ-027 `EXE_MUL, `WORD_LEN, `EXE_CMD_LEN and state encodings (`MUL_IDLE, `MUL_BUSY, `MUL_DONE) in shared defines.v.
REQ-028 One sub-module exe_mul_datapath: prod/mcand/mplr/cnt registers and adder; exe_mul_seq keeps FSM and output muxing.
REQ-029 exe_stall ORed with the hazard-unit freeze at the top level, outside this block.

Verification
REQ-030 val1=7, val2=6, EXE_MUL -> exe_stall=1 T0..T3, T4 mul_valid=1, result_out=42, exe_stall=0.
REQ-031 val1=val2=0xFFFFFFFF -> 32 BUSY cycles, exe_stall=1 T0..T32, T33 mul_valid=1, result_out=0x00000001.
REQ-032 val1=0x1234, val2=0 -> exe_stall=1 at T0 only, T1 mul_valid=1, result_out=0.
REQ-033 Two consecutive MULs (3*5 then 0x10000*0x10000) -> results 15 then 0x00000000, second accepted in the IDLE cycle after first DONE.
REQ-034 rst=1 during BUSY of 0xFFFFFFFF*0xFFFFFFFF -> next cycle IDLE, exe_stall=0, no mul_valid, result_out=alu_res_in.
REQ-035 Non-MUL command, alu_res_in=0xDEADBEEF -> result_out=0xDEADBEEF, exe_stall=0, mul_valid=0 same cycle.

Source files
------------

// File: rtl/exe_mul_seq_pkg.sv
// Shared constants, command encoding and FSM state type for the sequential
// shift-and-add multiplier that sits in the EXE stage.
package exe_mul_seq_pkg;

    localparam int DEF_WORD_LEN    = 32;
    localparam int DEF_CNT_LEN     = 5;
    localparam int EXE_CMD_LEN     = 4;

    localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = 4'd12;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic logic is_mul(input logic [EXE_CMD_LEN-1:0] cmd);
        return cmd == EXE_MUL;
    endfunction

endpackage

// File: rtl/exe_mul_seq_if.sv
// EXE-stage bus between the pipeline (master) and the multiplier (slave).
interface exe_mul_seq_if import exe_mul_seq_pkg::*; #(
    parameter int WORD_LEN = DEF_WORD_LEN
) ();

    logic [EXE_CMD_LEN-1:0] EXE_CMD;
    logic [WORD_LEN-1:0]    val1;
    logic [WORD_LEN-1:0]    val2;
    logic [WORD_LEN-1:0]    alu_res_in;
    logic                   exe_stall;
    logic                   mul_valid;
    logic [WORD_LEN-1:0]    result_out;

    modport master (
        output EXE_CMD, val1, val2, alu_res_in,
        input  exe_stall, mul_valid, result_out
    );

    modport slave (
        input  EXE_CMD, val1, val2, alu_res_in,
        output exe_stall, mul_valid, result_out
    );

endinterface

// File: rtl/exe_mul_seq_datapath.sv
// Shift-and-add datapath: product accumulator, shifting multiplicand and
// multiplier, iteration counter. Sequencing comes from exe_mul_seq.
module exe_mul_datapath #(
    parameter int WORD_LEN = 32,
    parameter int CNT_LEN  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [WORD_LEN-1:0] mcand_in,
    input  logic [WORD_LEN-1:0] mplr_in,
    output logic [WORD_LEN-1:0] prod,
    output logic                last_iter
);

    logic [WORD_LEN-1:0] prod_q,  prod_d;
    logic [WORD_LEN-1:0] mcand_q, mcand_d;
    logic [WORD_LEN-1:0] mplr_q,  mplr_d;
    logic [CNT_LEN-1:0]  cnt_q,   cnt_d;
    logic [WORD_LEN-1:0] addend;
    logic [WORD_LEN-1:0] mplr_shift;

    // Partial product: the multiplicand gated by the current multiplier LSB.
    for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_addend
        assign addend[gi] = mcand_q[gi] & mplr_q[0];
    end

    assign mplr_shift = mplr_q >> 1;
    assign last_iter  = (mplr_shift == '0) || (cnt_q == CNT_LEN'(WORD_LEN - 1));
    assign prod       = prod_q;

    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        if (load) begin
            prod_d  = '0;
            mcand_d = mcand_in;
            mplr_d  = mplr_in;
            cnt_d   = '0;
        end else if (step) begin
            prod_d  = prod_q + addend;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_shift;
            cnt_d   = cnt_q + CNT_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/exe_mul_seq.sv
// EXE-stage sequential multiplier: IDLE/BUSY/DONE control, pipeline stall
// generation and result muxing between the ALU result and the product.
module exe_mul_seq import exe_mul_seq_pkg::*; #(
    parameter int WORD_LEN = DEF_WORD_LEN,
    parameter int CNT_LEN  = DEF_CNT_LEN
) (
    input  logic          clk,
    input  logic          rst,
    exe_mul_seq_if.slave  bus
);

    mul_state_e          state_q, state_d;
    logic                accept;
    logic                step;
    logic                last_iter;
    logic [WORD_LEN-1:0] prod;
    logic                exe_stall;
    logic                mul_valid;
    logic [WORD_LEN-1:0] result_out;

    // Operands are captured only here; later changes on val1/val2 are ignored.
    assign accept = (state_q == MUL_IDLE) && is_mul(bus.EXE_CMD) && !rst;
    assign step   = (state_q == MUL_BUSY);

    exe_mul_datapath #(
        .WORD_LEN (WORD_LEN),
        .CNT_LEN  (CNT_LEN)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (step),
        .mcand_in  (bus.val1),
        .mplr_in   (bus.val2),
        .prod      (prod),
        .last_iter (last_iter)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: begin
                if (accept) begin
                    state_d = (bus.val2 == '0) ? MUL_DONE : MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (last_iter) begin
                    state_d = MUL_DONE;
                end
            end
            // A MUL still held on EXE_CMD during DONE is not re-accepted.
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        exe_stall  = 1'b0;
        mul_valid  = 1'b0;
        result_out = bus.alu_res_in;
        if (!rst) begin
            case (state_q)
                MUL_IDLE: exe_stall = accept;
                MUL_BUSY: exe_stall = 1'b1;
                MUL_DONE: begin
                    mul_valid  = 1'b1;
                    result_out = prod;
                end
                default: ;
            endcase
        end
    end

    assign bus.exe_stall  = exe_stall;
    assign bus.mul_valid  = mul_valid;
    assign bus.result_out = result_out;

endmodule

// File: tb/tb_exe_mul_seq.sv
// Randomized scoreboard bench for exe_mul_seq: the driver pushes expected
// product and completion cycle, a negedge monitor checks every cycle.
module tb_exe_mul_seq;
    import exe_mul_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_mul_seq_if #(.WORD_LEN(32)) bus ();

    exe_mul_seq #(
        .WORD_LEN (32),
        .CNT_LEN  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        int          acc;
        int          done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width product truncated to the word.
    function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // Reference: iterations = index of the highest set multiplier bit plus one.
    function automatic int ref_iters(input logic [31:0] b);
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [EXE_CMD_LEN-1:0] rand_alu_cmd();
        logic [EXE_CMD_LEN-1:0] c;
        c = EXE_CMD_LEN'($urandom_range(0, 15));
        while (c == EXE_MUL) c = EXE_CMD_LEN'($urandom_range(0, 15));
        return c;
    endfunction

    task automatic alu_op(input int n, input logic [31:0] res);
        for (int i = 0; i < n; i++) begin
            bus.EXE_CMD    = rand_alu_cmd();
            bus.alu_res_in = (i == 0) ? res : $urandom;
            @(posedge clk); #1;
        end
    endtask

    // Issues a MUL, scrambles operands while it is in flight, returns in the
    // IDLE cycle right after DONE so a following op can be accepted at once.
    task automatic send_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        bus.EXE_CMD    = EXE_MUL;
        bus.val1       = a;
        bus.val2       = b;
        bus.alu_res_in = $urandom;
        x.a    = a;
        x.b    = b;
        x.prod = ref_prod(a, b);
        x.acc  = cyc;
        x.done = cyc + 1 + ref_iters(b);
        sb.push_back(x);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
            @(posedge clk); #1;
            bus.val1       = $urandom;
            bus.val2       = $urandom;
            bus.alu_res_in = $urandom;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        total++;
        if (bus.exe_stall && bus.mul_valid) begin
            bad++;
            $display("FAIL excl cyc=%0d stall=%0b valid=%0b required not both high", cyc, bus.exe_stall, bus.mul_valid);
        end
        if (rst) begin
            sb.delete();
            total++;
            if (bus.exe_stall || bus.mul_valid || bus.result_out != bus.alu_res_in) begin
                bad++;
                $display("FAIL reset_out cyc=%0d stall=%0b valid=%0b result=%h required 0 0 %h",
                         cyc, bus.exe_stall, bus.mul_valid, bus.result_out, bus.alu_res_in);
            end
        end else if (bus.mul_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL spurious_valid cyc=%0d result=%h required no valid", cyc, bus.result_out);
            end else begin
                e = sb.pop_front();
                if (bus.result_out != e.prod || cyc != e.done) begin
                    bad++;
                    $display("FAIL mul %h*%h result=%h at cyc %0d required %h at cyc %0d",
                             e.a, e.b, bus.result_out, cyc, e.prod, e.done);
                end else begin
                    $display("mul %h*%h = %h accepted cyc %0d done cyc %0d",
                             e.a, e.b, bus.result_out, e.acc, cyc);
                end
            end
        end else if (sb.size() != 0) begin
            total++;
            if (cyc >= sb[0].done) begin
                e = sb.pop_front();
                bad++;
                $display("FAIL missing_valid %h*%h cyc=%0d valid=0 required valid=1 result %h",
                         e.a, e.b, cyc, e.prod);
            end else if (!bus.exe_stall) begin
                bad++;
                $display("FAIL stall cyc=%0d stall=0 required 1 (accepted cyc %0d)", cyc, sb[0].acc);
            end
        end else if (bus.EXE_CMD != EXE_MUL) begin
            total++;
            if (bus.exe_stall || bus.result_out != bus.alu_res_in) begin
                bad++;
                $display("FAIL idle_out cyc=%0d stall=%0b result=%h required 0 %h",
                         cyc, bus.exe_stall, bus.result_out, bus.alu_res_in);
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        bus.EXE_CMD    = '0;
        bus.val1       = '0;
        bus.val2       = '0;
        bus.alu_res_in = 32'h0BAD_F00D;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        alu_op(1, 32'hDEAD_BEEF);
        send_mul(32'd7, 32'd6);
        alu_op(1, $urandom);
        send_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_mul(32'h0000_1234, 32'd0);
        alu_op(1, $urandom);
        send_mul(32'd3, 32'd5);
        send_mul(32'h0001_0000, 32'h0001_0000);
        alu_op(2, $urandom);

        // Reset in the middle of a long multiply: must vanish without a result.
        bus.EXE_CMD = EXE_MUL;
        bus.val1    = 32'hFFFF_FFFF;
        bus.val2    = 32'hFFFF_FFFF;
        e.a = 32'hFFFF_FFFF; e.b = 32'hFFFF_FFFF;
        e.prod = ref_prod(e.a, e.b);
        e.acc  = cyc;
        e.done = cyc + 1 + ref_iters(e.b);
        sb.push_back(e);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        alu_op(3, $urandom);
        send_mul(32'd9, 32'd11);

        repeat (40) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            send_mul(a, b);
            if ($urandom_range(0, 1) == 1) alu_op($urandom_range(1, 3), $urandom);
        end

        alu_op(3, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
